mpt_req_fetch: RTL and testbench

- MPT-side consumer of the selected-channel handshake.
- Watches the selected-channel word from the channel-select controller. When the Ready bit is set, it pops exactly one request from the chosen channel's request FIFO.
- Pulses req_read_already back to the controller so it can clear Ready.
- Presents the fetched request, tagged with its channel index, to the MPT lookup pipeline over a valid/ready handshake.

---
 rtl/mpt_req_fetch_if.sv | 25 ++
 rtl/mpt_req_fetch.sv | 108 ++++++++++
 tb/tb_mpt_req_fetch.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/mpt_req_fetch_if.sv
// Request handshake from the fetch stage into the MPT lookup pipeline.
// The master side (mpt_req_fetch) drives the request; the slave side accepts it.
interface mpt_req_fetch_if #(
    parameter int REQ_WIDTH = 128,
    parameter int IDX_WIDTH = 3
);
    logic                 o_req_valid;
    logic [REQ_WIDTH-1:0] ov_req_data;
    logic [IDX_WIDTH-1:0] ov_req_chnl;
    logic                 i_req_ready;

    modport master (
        output o_req_valid,
        output ov_req_data,
        output ov_req_chnl,
        input  i_req_ready
    );

    modport slave (
        input  o_req_valid,
        input  ov_req_data,
        input  ov_req_chnl,
        output i_req_ready
    );
endinterface

// File: rtl/mpt_req_fetch.sv
// Pops one request from the channel chosen by the select controller, acknowledges
// the pop, and hands the request with its channel index to the MPT lookup pipeline.
module mpt_req_fetch #(
    parameter int CHANNEL_NUM   = 8,
    parameter int CHANNEL_WIDTH = 9,
    parameter int REQ_WIDTH     = 128,
    parameter int IDX_WIDTH     = 3
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [CHANNEL_WIDTH-1:0]         iv_selected_channel,
    output logic                             o_req_read_already,
    input  logic [CHANNEL_NUM-1:0]           iv_req_empty,
    output logic [CHANNEL_NUM-1:0]           ov_req_rd_en,
    input  logic [CHANNEL_NUM*REQ_WIDTH-1:0] iv_req_dout,
    mpt_req_fetch_if.master                  req_if,
    output logic                             o_sel_err,
    output logic [31:0]                      ov_fetch_cnt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        OUT     = 2'd2
    } state_t;

    state_t state;

    logic                   sel_ready;
    logic [CHANNEL_NUM-1:0] sel_field;
    logic [IDX_WIDTH-1:0]   sel_idx;
    logic [CHANNEL_NUM-1:0] sel_onehot;
    logic                   sel_empty;
    logic                   fetch;
    logic [REQ_WIDTH-1:0]   dout_sel;

    function automatic logic [IDX_WIDTH-1:0] lowest_idx(input logic [CHANNEL_NUM-1:0] f);
        lowest_idx = '0;
        for (int i = CHANNEL_NUM - 1; i >= 0; i--) begin
            if (f[i]) lowest_idx = IDX_WIDTH'(i);
        end
    endfunction

    function automatic logic is_multi_hot(input logic [CHANNEL_NUM-1:0] f);
        is_multi_hot = (f & (f - CHANNEL_NUM'(1))) != '0;
    endfunction

    assign sel_ready = iv_selected_channel[CHANNEL_WIDTH-1];
    assign sel_field = iv_selected_channel[CHANNEL_NUM-1:0];

    // A multi-hot field is resolved to its lowest set bit; the error flag records it.
    always_comb begin
        sel_idx      = lowest_idx(sel_field);
        sel_onehot   = CHANNEL_NUM'(1) << sel_idx;
        sel_empty    = |(sel_onehot & iv_req_empty);
        fetch        = (state == IDLE) && sel_ready && (sel_field != '0) && !sel_empty;
        ov_req_rd_en = fetch ? sel_onehot : '0;
    end

    always_comb begin
        dout_sel = '0;
        for (int i = 0; i < CHANNEL_NUM; i++) begin
            if (req_if.ov_req_chnl == IDX_WIDTH'(i))
                dout_sel = iv_req_dout[i*REQ_WIDTH +: REQ_WIDTH];
        end
    end

    // Ready is only examined in IDLE, so a Ready still high during RD_WAIT can
    // never trigger a second pop of the same selection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state              <= IDLE;
            o_req_read_already <= 1'b0;
            req_if.o_req_valid <= 1'b0;
            req_if.ov_req_data <= '0;
            req_if.ov_req_chnl <= '0;
            o_sel_err          <= 1'b0;
            ov_fetch_cnt       <= '0;
        end else begin
            o_req_read_already <= 1'b0;
            case (state)
                IDLE: begin
                    if (sel_ready && ((sel_field == '0) || is_multi_hot(sel_field)))
                        o_sel_err <= 1'b1;
                    if (fetch) begin
                        req_if.ov_req_chnl <= sel_idx;
                        o_req_read_already <= 1'b1;
                        state              <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    req_if.ov_req_data <= dout_sel;
                    req_if.o_req_valid <= 1'b1;
                    ov_fetch_cnt       <= ov_fetch_cnt + 32'd1;
                    state              <= OUT;
                end
                OUT: begin
                    if (req_if.i_req_ready) begin
                        req_if.o_req_valid <= 1'b0;
                        state              <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mpt_req_fetch.sv
// Directed bench for mpt_req_fetch: the bench plays the select controller and
// the per-channel request FIFOs, and checks every output against hand values.
module tb_mpt_req_fetch;
    localparam int CN = 8;
    localparam int CW = 9;
    localparam int RW = 128;
    localparam int IW = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic [CW-1:0]     sel;
    logic              read_already;
    logic [CN-1:0]     empty;
    logic [CN-1:0]     rd_en;
    logic [CN*RW-1:0]  dout;
    logic              sel_err;
    logic [31:0]       fetch_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    mpt_req_fetch_if #(.REQ_WIDTH(RW), .IDX_WIDTH(IW)) mif ();

    mpt_req_fetch #(
        .CHANNEL_NUM(CN), .CHANNEL_WIDTH(CW), .REQ_WIDTH(RW), .IDX_WIDTH(IW)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .iv_selected_channel(sel),
        .o_req_read_already (read_already),
        .iv_req_empty       (empty),
        .ov_req_rd_en       (rd_en),
        .iv_req_dout        (dout),
        .req_if             (mif.master),
        .o_sel_err          (sel_err),
        .ov_fetch_cnt       (fetch_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [RW-1:0] chdata(input int i);
        if (i == 2) return 128'hA5;
        return {32'hC0DE_0000 | 32'(i), 64'h0, 32'h1000_0000 + 32'(i)};
    endfunction

    task automatic check(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a select for channel ch and walk one full fetch with ready high.
    task automatic one_fetch(input string tag, input int ch, input logic [31:0] exp_cnt);
        sel = CW'(9'h100 | (9'h1 << ch));
        #1;
        check({tag, "_rd_en"}, RW'(rd_en), RW'(8'h1 << ch));
        tick();
        check({tag, "_rd_en_once"}, RW'(rd_en), '0);
        check({tag, "_read_already"}, RW'(read_already), 1);
        sel = '0;
        tick();
        check({tag, "_ra_pulse"}, RW'(read_already), 0);
        check({tag, "_valid"}, RW'(mif.o_req_valid), 1);
        check({tag, "_data"}, mif.ov_req_data, chdata(ch));
        check({tag, "_chnl"}, RW'(mif.ov_req_chnl), RW'(ch));
        check({tag, "_cnt"}, RW'(fetch_cnt), RW'(exp_cnt));
        tick();
        check({tag, "_valid_drop"}, RW'(mif.o_req_valid), 0);
    endtask

    initial begin
        int rd_cnt;
        int ra_cnt;
        int hs_cnt;
        int k;
        int order [3];
        int got_ch [3];
        logic [31:0] base;

        order = '{0, 5, 7};
        got_ch = '{-1, -1, -1};
        for (int i = 0; i < CN; i++) dout[i*RW +: RW] = chdata(i);
        rst = 1'b1;
        sel = '0;
        empty = '0;
        mif.i_req_ready = 1'b1;
        tick();
        tick();
        check("rst_valid", RW'(mif.o_req_valid), 0);
        check("rst_data", mif.ov_req_data, '0);
        check("rst_chnl", RW'(mif.ov_req_chnl), 0);
        check("rst_ra", RW'(read_already), 0);
        check("rst_rd_en", RW'(rd_en), 0);
        check("rst_err", RW'(sel_err), 0);
        check("rst_cnt", RW'(fetch_cnt), 0);
        rst = 1'b0;
        tick();

        // Basic fetch of channel 2
        one_fetch("basic", 2, 32'd1);

        // Backpressure on channel 5, with a new select arriving while held
        mif.i_req_ready = 1'b0;
        sel = 9'h120;
        #1;
        check("bp_rd_en", RW'(rd_en), 8'h20);
        tick();
        sel = '0;
        tick();
        sel = 9'h101;
        for (int c = 0; c < 5; c++) begin
            #1;
            check("bp_valid", RW'(mif.o_req_valid), 1);
            check("bp_data", mif.ov_req_data, chdata(5));
            check("bp_chnl", RW'(mif.ov_req_chnl), 5);
            check("bp_no_rd", RW'(rd_en), 0);
            tick();
        end
        mif.i_req_ready = 1'b1;
        tick();
        check("bp_released", RW'(mif.o_req_valid), 0);
        one_fetch("bp_ch0", 0, 32'd3);

        // Empty stall on channel 7
        empty = 8'h80;
        sel = 9'h180;
        for (int c = 0; c < 4; c++) begin
            #1;
            check("stall_rd", RW'(rd_en), 0);
            check("stall_ra", RW'(read_already), 0);
            tick();
        end
        empty = '0;
        one_fetch("stall", 7, 32'd4);

        // Zero-hot select, then multi-hot select
        sel = 9'h100;
        #1;
        check("zero_rd", RW'(rd_en), 0);
        tick();
        check("zero_err", RW'(sel_err), 1);
        check("zero_ra", RW'(read_already), 0);
        sel = 9'h10A;
        #1;
        check("multi_rd", RW'(rd_en), 8'h02);
        tick();
        sel = '0;
        tick();
        check("multi_chnl", RW'(mif.ov_req_chnl), 1);
        check("multi_data", mif.ov_req_data, chdata(1));
        check("multi_err", RW'(sel_err), 1);
        tick();

        // Back-to-back: the next selection is loaded as soon as the pop is acked
        base = fetch_cnt;
        rd_cnt = 0; ra_cnt = 0; hs_cnt = 0;
        sel = CW'(9'h100 | (9'h1 << order[0]));
        k = 1;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (rd_en != '0) rd_cnt++;
            if (mif.o_req_valid && mif.i_req_ready && hs_cnt < 3) begin
                got_ch[hs_cnt] = int'(mif.ov_req_chnl);
                check("b2b_data", mif.ov_req_data, chdata(order[hs_cnt]));
                hs_cnt++;
            end
            if (read_already) begin
                ra_cnt++;
                sel = (k < 3) ? CW'(9'h100 | (9'h1 << order[k])) : '0;
                k++;
            end
            tick();
        end
        check("b2b_rd_cnt", RW'(rd_cnt), 3);
        check("b2b_ra_cnt", RW'(ra_cnt), 3);
        check("b2b_hs_cnt", RW'(hs_cnt), 3);
        for (int i = 0; i < 3; i++) check("b2b_order", RW'(got_ch[i]), RW'(order[i]));
        check("b2b_cnt", RW'(fetch_cnt), RW'(base + 32'd3));

        // Asynchronous reset while holding a request in OUT
        mif.i_req_ready = 1'b0;
        sel = 9'h108;
        tick();
        sel = '0;
        tick();
        check("mid_valid_pre", RW'(mif.o_req_valid), 1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_valid", RW'(mif.o_req_valid), 0);
        check("mid_data", mif.ov_req_data, '0);
        check("mid_chnl", RW'(mif.ov_req_chnl), 0);
        check("mid_cnt", RW'(fetch_cnt), 0);
        check("mid_err", RW'(sel_err), 0);
        tick();
        rst = 1'b0;
        mif.i_req_ready = 1'b1;
        tick();
        one_fetch("post_rst", 6, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
